// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_pkg
//  Description : Shared state encoding and default widths for the
//                counter_seq_ctrl run/pause/abort counter controller.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_seq_pkg;

  localparam int c_default_width  = 4;
  localparam int c_default_pass_w = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_seq_ctrl_tff_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_counter
//  Description : WIDTH-bit synchronous up counter built from T flip-flops.
//                Bit i toggles when the enable is high and every lower bit
//                is 1. Synchronous clear overrides counting.
//  Revision    : 1.0  initial release
// ============================================================================
module tff_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] w_t;

  // Per-bit toggle enables: a bit flips only when all bits below it are set.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_toggle
      if (i == 0) begin : g_lsb
        assign w_t[i] = en;
      end else begin : g_upper
        assign w_t[i] = en & (&q[i-1:0]);
      end
    end
  endgenerate

  // Count register: reset or clear forces zero, otherwise toggle selected bits.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      q <= '0;
    end else begin
      q <= q ^ w_t;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_ctrl
//  Description : Run controller for a 0..limit counter. Counts a programmed
//                number of full wraps (or forever when passes is 0), supports
//                pause and abort, and pulses done for one cycle on normal
//                completion. y flags the count matching either latched
//                compare value while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = c_default_width,
  parameter int PASS_W = c_default_pass_w
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  input  logic [WIDTH-1:0]  cmp_a,
  input  logic [WIDTH-1:0]  cmp_b,
  output logic [WIDTH-1:0]  q,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_limit;
  logic [WIDTH-1:0]   r_cmp_a;
  logic [WIDTH-1:0]   r_cmp_b;
  logic [PASS_W-1:0]  r_passes;
  logic [PASS_W-1:0]  r_pass_cnt;
  logic [PASS_W-1:0]  w_pass_inc;
  logic               w_accept;
  logic               w_step;
  logic               w_kill;
  logic               w_wrap;
  logic               w_finish;
  logic               w_cnt_en;
  logic               w_cnt_clear;

  assign w_pass_inc = r_pass_cnt + {{(PASS_W-1){1'b0}}, 1'b1};

  // Next-state and step decode. Leaving PAUSE with pause low counts on that
  // same edge, so a pause held for N edges delays the run by exactly N.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_kill       = 1'b0;
    w_wrap       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort) begin
          w_kill       = 1'b1;
          w_next_state = S_IDLE;
        end else if (pause) begin
          w_next_state = S_PAUSE;
        end else begin
          w_step       = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    w_wrap   = w_step && (q == r_limit);
    w_finish = w_wrap && (r_passes != '0) && (w_pass_inc == r_passes);
    if (w_finish) begin
      w_next_state = S_DONE;
    end
  end

  // Wrap, abort and start acceptance all return the counter to zero via clear.
  assign w_cnt_en    = w_step && !w_wrap;
  assign w_cnt_clear = w_accept || w_wrap || w_kill;

  // State, latched run parameters and completed-wrap count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_limit    <= '0;
      r_passes   <= '0;
      r_cmp_a    <= '0;
      r_cmp_b    <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_limit    <= limit;
        r_passes   <= passes;
        r_cmp_a    <= cmp_a;
        r_cmp_b    <= cmp_b;
        r_pass_cnt <= '0;
      end else if (w_kill) begin
        r_pass_cnt <= '0;
      end else if (w_wrap) begin
        r_pass_cnt <= w_pass_inc;
      end
    end
  end

  tff_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (w_cnt_en),
    .clear (w_cnt_clear),
    .q     (q)
  );

  assign busy     = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done     = (r_state == S_DONE);
  assign pass_cnt = r_pass_cnt;
  assign y        = busy && ((q == r_cmp_a) || (q == r_cmp_b));

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_seq_ctrl
//  Description : Self-checking bench for counter_seq_ctrl: directed run
//                scenarios followed by random traffic, all compared against
//                a behavioural run model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [3:0] limit, passes, cmp_a, cmp_b;
  logic [3:0] q, pass_cnt;
  logic       y, busy, done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Behavioural model of a run
  bit m_active, m_done;
  int m_count, m_wraps, m_lim, m_npass, m_ca, m_cb;

  counter_seq_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .limit(limit), .passes(passes), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .q(q), .y(y), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    if (!reset) begin
      m_active = 0; m_done = 0; m_count = 0; m_wraps = 0;
      m_lim = 0; m_npass = 0; m_ca = 0; m_cb = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1; m_count = 0; m_wraps = 0;
        m_lim = limit; m_npass = passes; m_ca = cmp_a; m_cb = cmp_b;
      end
    end else if (abort) begin
      m_active = 0; m_count = 0; m_wraps = 0;
    end else if (!pause) begin
      if (m_count == m_lim) begin
        m_count = 0;
        m_wraps = (m_wraps + 1) % 16;
        if (m_npass != 0 && m_wraps == m_npass) begin
          m_active = 0; m_done = 1;
        end
      end else begin
        m_count = m_count + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("q", 32'(q), 32'(m_count));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("pass_cnt", 32'(pass_cnt), 32'(m_wraps));
    check("y", 32'(y), 32'(m_active && (m_count == m_ca || m_count == m_cb)));
    if (done) done_seen++;
  endtask

  // One cycle: drive at the falling edge, model the rising edge, compare after.
  task automatic tick(input logic rs, input logic st, input logic pa, input logic ab,
                      input logic [3:0] li, input logic [3:0] ps,
                      input logic [3:0] ca, input logic [3:0] cb);
    reset = rs; start = st; pause = pa; abort = ab;
    limit = li; passes = ps; cmp_a = ca; cmp_b = cb;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
  endtask

  initial begin
    reset = 0; start = 0; pause = 0; abort = 0;
    limit = 0; passes = 0; cmp_a = 0; cmp_b = 0;
    @(negedge clk);
    tick(0, 1, 0, 0, 4'd5, 4'd1, 4'd0, 4'd0);
    tick(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    check("reset_q", 32'(q), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // limit 9, one pass, decode at 3 and 9
    done_seen = 0;
    tick(1, 1, 0, 0, 4'd9, 4'd1, 4'd3, 4'd9);
    idle_ticks(10);
    check("r37_done", 32'(done), 32'd1);
    check("r37_pass", 32'(pass_cnt), 32'd1);
    idle_ticks(2);
    check("r37_pass_hold", 32'(pass_cnt), 32'd1);
    check("r37_done_cnt", 32'(done_seen), 32'd1);

    // limit 2, three passes
    done_seen = 0;
    tick(1, 1, 0, 0, 4'd2, 4'd3, 4'd1, 4'd7);
    idle_ticks(9);
    check("r38_done", 32'(done), 32'd1);
    check("r38_pass", 32'(pass_cnt), 32'd3);
    idle_ticks(3);
    check("r38_busy", 32'(busy), 32'd0);
    check("r38_done_cnt", 32'(done_seen), 32'd1);

    // limit 5 with a three-edge pause at q=2
    tick(1, 1, 0, 0, 4'd5, 4'd1, 4'd2, 4'd5);
    idle_ticks(2);
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    check("r39_frozen", 32'(q), 32'd2);
    idle_ticks(1);
    check("r39_resume", 32'(q), 32'd3);
    idle_ticks(3);
    check("r39_done", 32'(done), 32'd1);
    idle_ticks(1);

    // endless run, then abort
    done_seen = 0;
    tick(1, 1, 0, 0, 4'd15, 4'd0, 4'd4, 4'd12);
    idle_ticks(40);
    check("r40_pass", 32'(pass_cnt), 32'd2);
    tick(1, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    check("r40_idle", 32'(busy), 32'd0);
    check("r40_q", 32'(q), 32'd0);
    check("r40_no_done", 32'(done_seen), 32'd0);

    // start+abort in IDLE, then a restart attempt mid-run
    tick(1, 1, 0, 1, 4'd3, 4'd1, 4'd0, 4'd0);
    check("r41_idle", 32'(busy), 32'd0);
    tick(1, 1, 0, 0, 4'd4, 4'd1, 4'd0, 4'd0);
    tick(1, 1, 0, 0, 4'd1, 4'd1, 4'd0, 4'd0);
    idle_ticks(3);
    check("r41_limit_kept", 32'(q), 32'd4);
    idle_ticks(3);

    // reset mid-run at q=7, then limit 0 with two passes
    tick(1, 1, 0, 0, 4'd15, 4'd0, 4'd7, 4'd0);
    idle_ticks(7);
    check("r42_q7", 32'(q), 32'd7);
    tick(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    check("r42_rst_q", 32'(q), 32'd0);
    check("r42_rst_busy", 32'(busy), 32'd0);
    tick(1, 1, 0, 0, 4'd0, 4'd2, 4'd9, 4'd9);
    idle_ticks(2);
    check("r42_done", 32'(done), 32'd1);
    idle_ticks(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 31) == 0),
           4'($urandom_range(0, 6)),
           4'($urandom_range(0, 3)),
           4'($urandom_range(0, 7)),
           4'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
